// File: rtl/imager_rx.sv
// imager_rx: receive side of a parallel fv/lv sensor stream.
// Locks to frame boundaries, re-emits active pixels with row/column
// coordinates, measures frame geometry and blanking, and keeps sticky
// protocol error flags. Define IMAGER_RX_CHECKSUM_EN to build the per-frame
// pixel checksum; without it o_frame_checksum is tied to zero.
module imager_rx #(
  parameter int DATA_WIDTH     = 10,
  parameter int NUM_ROWS_WIDTH = 12,
  parameter int NUM_COLS_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_enable,
  input  logic                      i_clear_err,
  input  logic [DATA_WIDTH-1:0]     i_dat,
  input  logic                      i_fv,
  input  logic                      i_lv,
  output logic [DATA_WIDTH-1:0]     o_pix_dat,
  output logic [NUM_ROWS_WIDTH-1:0] o_pix_row,
  output logic [NUM_COLS_WIDTH-1:0] o_pix_col,
  output logic                      o_pix_valid,
  output logic                      o_pix_sof,
  output logic                      o_pix_eol,
  output logic                      o_frame_done,
  output logic [NUM_ROWS_WIDTH-1:0] o_meas_rows,
  output logic [NUM_COLS_WIDTH-1:0] o_meas_cols,
  output logic [NUM_COLS_WIDTH-1:0] o_meas_hblank,
  output logic [23:0]               o_meas_vblank,
  output logic [15:0]               o_frame_count,
  output logic                      o_err_line_len,
  output logic                      o_err_lv_no_fv,
  output logic [31:0]               o_frame_checksum
);

  typedef enum logic [1:0] {SYNC, WAIT_FV, ACTIVE} state_t;

  localparam logic [NUM_ROWS_WIDTH-1:0] ROW_MAX    = '1;
  localparam logic [NUM_COLS_WIDTH-1:0] COL_MAX    = '1;
  localparam logic [23:0]               VBLANK_MAX = '1;

  state_t                    r_state;
  state_t                    w_next_state;

  logic [DATA_WIDTH-1:0]     r_s1_dat;
  logic                      r_s1_fv;
  logic                      r_s1_lv;
  logic [DATA_WIDTH-1:0]     r_s2_dat;
  logic                      r_s2_fv;
  logic                      r_s2_lv;

  logic [NUM_ROWS_WIDTH-1:0] r_row;
  logic [NUM_COLS_WIDTH-1:0] r_col;
  logic [NUM_COLS_WIDTH-1:0] r_line0_len;
  logic [NUM_COLS_WIDTH-1:0] r_hblank_cnt;
  logic [23:0]               r_vblank_cnt;

  logic [NUM_ROWS_WIDTH-1:0] r_meas_rows;
  logic [NUM_COLS_WIDTH-1:0] r_meas_cols;
  logic [NUM_COLS_WIDTH-1:0] r_meas_hblank;
  logic [23:0]               r_meas_vblank;
  logic [15:0]               r_frame_count;
  logic                      r_frame_done;
  logic                      r_err_line_len;
  logic                      r_err_lv_no_fv;

  logic                      w_fv_rise;
  logic                      w_emit;
  logic                      w_line_close;
  logic                      w_frame_start;
  logic                      w_frame_end;
  logic                      w_len_err;
  logic                      w_lv_no_fv;
  logic [NUM_COLS_WIDTH-1:0] w_line_len;
  logic [NUM_ROWS_WIDTH-1:0] w_row_inc;

  // Pixel in s2 belongs to the frame while ACTIVE; s1 is the lookahead
  // sample that tells whether that pixel ends its line or the frame.
  assign w_fv_rise     = r_s1_fv && !r_s2_fv;
  assign w_emit        = (r_state == ACTIVE) && r_s2_fv && r_s2_lv;
  assign w_line_close  = w_emit && (!r_s1_lv || !r_s1_fv);
  assign w_frame_start = i_enable && (r_state == WAIT_FV) && w_fv_rise;
  assign w_frame_end   = i_enable && (r_state == ACTIVE) && !r_s1_fv;
  assign w_line_len    = (r_col == COL_MAX) ? COL_MAX : r_col + NUM_COLS_WIDTH'(1);
  assign w_row_inc     = (r_row == ROW_MAX) ? ROW_MAX : r_row + NUM_ROWS_WIDTH'(1);
  assign w_len_err     = i_enable && w_line_close && (r_row != '0) &&
                         (w_line_len != r_line0_len);
  assign w_lv_no_fv    = i_enable && (r_state != SYNC) && r_s1_lv && !r_s1_fv;

  // Two-stage input capture: s1 is the sampled pin state, s2 the previous one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_dat <= '0;
      r_s1_fv  <= 1'b0;
      r_s1_lv  <= 1'b0;
      r_s2_dat <= '0;
      r_s2_fv  <= 1'b0;
      r_s2_lv  <= 1'b0;
    end else begin
      r_s1_dat <= i_dat;
      r_s1_fv  <= i_fv;
      r_s1_lv  <= i_lv;
      r_s2_dat <= r_s1_dat;
      r_s2_fv  <= r_s1_fv;
      r_s2_lv  <= r_s1_lv;
    end
  end

  // Frame-lock state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: resync on disable, skip any frame already running, then track fv.
  always_comb begin
    w_next_state = r_state;
    if (!i_enable) begin
      w_next_state = SYNC;
    end else begin
      case (r_state)
        SYNC:    if (!r_s1_fv) w_next_state = WAIT_FV;
        WAIT_FV: if (w_fv_rise) w_next_state = ACTIVE;
        ACTIVE:  if (!r_s1_fv) w_next_state = WAIT_FV;
        default: w_next_state = SYNC;
      endcase
    end
  end

  // Coordinates, blanking counters and end-of-frame measurement capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row         <= '0;
      r_col         <= '0;
      r_line0_len   <= '0;
      r_hblank_cnt  <= '0;
      r_vblank_cnt  <= '0;
      r_meas_rows   <= '0;
      r_meas_cols   <= '0;
      r_meas_hblank <= '0;
      r_meas_vblank <= '0;
      r_frame_count <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (i_enable) begin
        case (r_state)
          SYNC: begin
            r_vblank_cnt <= '0;
          end
          WAIT_FV: begin
            if (w_fv_rise) begin
              r_meas_vblank <= (r_vblank_cnt == VBLANK_MAX) ? VBLANK_MAX
                                                            : r_vblank_cnt + 24'd1;
              r_vblank_cnt  <= '0;
              r_row         <= '0;
              r_col         <= '0;
              r_line0_len   <= '0;
              r_hblank_cnt  <= '0;
            end else if (r_vblank_cnt != VBLANK_MAX) begin
              r_vblank_cnt <= r_vblank_cnt + 24'd1;
            end
          end
          ACTIVE: begin
            if (w_emit && !w_line_close && (r_col != COL_MAX)) begin
              r_col <= r_col + NUM_COLS_WIDTH'(1);
            end
            if (!r_s2_lv && (r_row == NUM_ROWS_WIDTH'(1)) && (r_hblank_cnt != COL_MAX)) begin
              r_hblank_cnt <= r_hblank_cnt + NUM_COLS_WIDTH'(1);
            end
            if (w_line_close) begin
              r_row <= w_row_inc;
              r_col <= '0;
              if (r_row == '0) begin
                r_line0_len <= w_line_len;
              end
            end
            if (w_frame_end) begin
              r_frame_done  <= 1'b1;
              r_meas_rows   <= w_line_close ? w_row_inc : r_row;
              r_meas_cols   <= (w_line_close && (r_row == '0)) ? w_line_len : r_line0_len;
              r_meas_hblank <= r_hblank_cnt;
              r_frame_count <= r_frame_count + 16'd1;
              r_vblank_cnt  <= '0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Sticky error flags; a fresh error outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_line_len <= 1'b0;
      r_err_lv_no_fv <= 1'b0;
    end else begin
      if (w_len_err) begin
        r_err_line_len <= 1'b1;
      end else if (i_clear_err) begin
        r_err_line_len <= 1'b0;
      end
      if (w_lv_no_fv) begin
        r_err_lv_no_fv <= 1'b1;
      end else if (i_clear_err) begin
        r_err_lv_no_fv <= 1'b0;
      end
    end
  end

`ifdef IMAGER_RX_CHECKSUM_EN
  logic [31:0] r_sum;
  logic [31:0] r_frame_checksum;
  logic [31:0] w_sum_next;

  assign w_sum_next = r_sum + (w_emit ? 32'(r_s2_dat) : 32'd0);

  // Running sum of emitted pixels, latched when the frame completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum            <= '0;
      r_frame_checksum <= '0;
    end else if (w_frame_start) begin
      r_sum <= '0;
    end else if (w_frame_end) begin
      r_sum            <= w_sum_next;
      r_frame_checksum <= w_sum_next;
    end else if (i_enable && w_emit) begin
      r_sum <= w_sum_next;
    end
  end

  assign o_frame_checksum = r_frame_checksum;
`else
  assign o_frame_checksum = 32'd0;
`endif

  assign o_pix_dat      = r_s2_dat;
  assign o_pix_row      = r_row;
  assign o_pix_col      = r_col;
  assign o_pix_valid    = w_emit;
  assign o_pix_sof      = w_emit && (r_row == '0) && (r_col == '0);
  assign o_pix_eol      = w_line_close;
  assign o_frame_done   = r_frame_done;
  assign o_meas_rows    = r_meas_rows;
  assign o_meas_cols    = r_meas_cols;
  assign o_meas_hblank  = r_meas_hblank;
  assign o_meas_vblank  = r_meas_vblank;
  assign o_frame_count  = r_frame_count;
  assign o_err_line_len = r_err_line_len;
  assign o_err_lv_no_fv = r_err_lv_no_fv;

endmodule

// File: doc/imager_rx.md
# imager_rx

Receive-side companion to the simulated imager: samples a parallel sensor stream (dat/fv/lv), locks to frame boundaries and re-emits active pixels with row/column coordinates. Measures frame geometry and blanking, flags protocol violations, and optionally checksums each frame. Sits between any fv/lv source (imager model or real sensor pins) and downstream pixel processing or bench scoreboards.

## Interface
- DATA_WIDTH, 10, pixel width
- NUM_ROWS_WIDTH, 12, row counter/measurement width
- NUM_COLS_WIDTH, 12, column counter/measurement width
- clk  in  1  pixel clock; all inputs sampled on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  receiver runs when high; low aborts and resynchronises
- clear_err  in  1  synchronous clear of sticky error flags
- dat  in  DATA_WIDTH  pixel data, valid when lv high
- fv  in  1  frame valid
- lv  in  1  line valid
- pix_dat  out  DATA_WIDTH  received pixel
- pix_row  out  NUM_ROWS_WIDTH  row index of pix_dat within frame
- pix_col  out  NUM_COLS_WIDTH  column index of pix_dat within line
- pix_valid  out  1  pix_* valid this cycle
- pix_sof  out  1  first pixel of frame (row 0, col 0)
- pix_eol  out  1  last pixel of line
- frame_done  out  1  one-cycle pulse at end of each complete frame
- meas_rows  out  NUM_ROWS_WIDTH  lines in last complete frame
- meas_cols  out  NUM_COLS_WIDTH  pixels in first line of last complete frame
- meas_hblank  out  NUM_COLS_WIDTH  lv-low cycles between line 0 and line 1 of last frame
- meas_vblank  out  24  fv-low cycles preceding the current/last frame
- frame_count  out  16  complete frames received, wraps
- err_line_len  out  1  sticky: a line length differed from line 0 of its frame
- err_lv_no_fv  out  1  sticky: lv sampled high while fv low
- frame_checksum  out  32  checksum of last complete frame

## Operation
- Input stage: dat/fv/lv registered once (s1); previous copy kept (s2) for edge detect. Edges are s1 vs s2.
- States: SYNC, WAIT_FV, ACTIVE. Reset and enable low force SYNC.
- SYNC: wait for sampled fv=0 -> WAIT_FV. A frame already in progress at enable is discarded.
- WAIT_FV: vblank counter increments each cycle (saturates at 2^24-1). On fv rise: meas_vblank <= count, count cleared, row/col cleared, checksum cleared -> ACTIVE.
- ACTIVE: each s1 lv-high cycle emits one pixel; col increments per pixel, saturating at all-ones. On lv fall: line length compared with line 0's (err_line_len on mismatch, lines >0), row increments (saturating), col cleared. hblank counted lv-low cycles between first lv fall and second lv rise.
- fv fall -> WAIT_FV; frame_done pulses; meas_rows/meas_cols/meas_hblank/frame_checksum updated same cycle; frame_count increments. If lv is high on the fv-fall sample, the line is closed as if lv fell simultaneously.
- err_lv_no_fv set whenever s1 lv=1 and s1 fv=0 in any state except SYNC; such pixels are not emitted.
- clear_err clears both flags; a new error in the same cycle wins (flag stays set).
- enable low mid-frame: no frame_done, measurements and frame_count unchanged, pix_valid low next cycle.

## Timing
- Reset values: all outputs 0; state SYNC.
- Latency: dat/lv presented before edge k -> pix_* valid after edge k+1 (2 register stages).
- pix_eol asserted with the pixel whose following sample has lv=0; requires one-cycle lookahead, so pix_* are driven from s2 relative to s1.
- frame_done asserted the cycle after the last pixel's pix_valid (or later if lv fell earlier).
- meas_vblank updates at frame start, not at frame_done.

## Configuration
- IMAGER_RX_CHECKSUM_EN defined: 32-bit modulo-2^32 sum of zero-extended emitted pixels per frame, latched to frame_checksum at frame_done.
- Not defined: checksum logic absent, frame_checksum tied to 0.

## Test plan
- Imager source 4 active rows, 2 virtual rows, 8 active cols, 4 virtual cols, vertical gradient: after second frame_done -> meas_rows=4, meas_cols=8, meas_hblank=4, meas_vblank=24, frame_count=2, pixels col 0..7 carry 2..9, frame_checksum=176 (with macro), no errors.
- Enable asserted mid-frame -> no pix_valid until next fv rise; first frame_done follows first complete frame only.
- Line 2 of 4 shortened to 7 pixels -> err_line_len=1 after that lv fall; clear_err pulse -> 0; meas_cols still 8.
- lv pulsed high 3 cycles during vblank -> err_lv_no_fv=1, no pix_valid during pulse.
- enable dropped at row 2 -> no frame_done, frame_count unchanged, state SYNC; re-enable resumes at next full frame.
- reset_n asserted mid-line -> all outputs 0 immediately (asynchronous), recovery as from power-on.
